// File: rtl/frec_div_multi_if.sv
// Configuration write bus for frec_div_multi.
//   wr_en    master->slave  one-cycle write strobe
//   wr_ch    master->slave  target channel
//   wr_div   master->slave  new period, in clockIn cycles
//   wr_high  master->slave  new high time, in clockIn cycles
//   wr_err   slave->master  one-cycle pulse: the previous write was rejected
// Handshake: wr_en is a valid strobe with no ready. The slave always consumes
// the strobe on the edge where it is high. The accept/reject verdict appears
// on wr_err one cycle later.
interface frec_div_multi_if #(
  parameter int NUM_CH = 4,
  parameter int DIV_W  = 24
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic             wr_en;
  logic [CH_W-1:0]  wr_ch;
  logic [DIV_W-1:0] wr_div;
  logic [DIV_W-1:0] wr_high;
  logic             wr_err;

  modport master (output wr_en, wr_ch, wr_div, wr_high, input wr_err);
  modport slave  (input wr_en, wr_ch, wr_div, wr_high, output wr_err);
endinterface

// File: rtl/frec_div_multi.sv
// Multi-channel programmable clock divider.
// Each channel has a run-time period (div) and high time (hi). A new
// configuration is held in a shadow copy and applied only at the period
// boundary, so the output never shows a runt or stretched pulse.
// Ports:
//   clockIn   system clock, all logic on posedge
//   reset     asynchronous, active-high
//   enable    per-channel run enable
//   cfg       configuration write bus (slave side)
//   pending   channel holds an accepted, not-yet-applied config
//   tick      one-cycle pulse on the first cycle of each period
//   clockOut  divided clocks, registered
module frec_div_multi #(
  parameter int NUM_CH   = 4,
  parameter int DIV_W    = 24,
  parameter int FrecIn   = 25000000,
  parameter int DEF_FREC = 1500
) (
  input  logic              clockIn,
  input  logic              reset,
  input  logic [NUM_CH-1:0] enable,
  frec_div_multi_if.slave   cfg,
  output logic [NUM_CH-1:0] pending,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] clockOut
);
  localparam logic [DIV_W-1:0] DEF_DIV = DIV_W'(FrecIn / DEF_FREC);
  localparam logic [DIV_W-1:0] DEF_HI  = DIV_W'((FrecIn / DEF_FREC) / 2);

  // The channel index is widened before the range check. When NUM_CH is a
  // power of two, every encodable index is valid.
  logic [31:0] ch_ext;
  logic        wr_ok;

  always_comb begin
    ch_ext = 32'(cfg.wr_ch);
    wr_ok  = cfg.wr_en
             && (ch_ext < 32'(NUM_CH))
             && (cfg.wr_div >= DIV_W'(2))
             && (cfg.wr_high != '0)
             && (cfg.wr_high < cfg.wr_div);
  end

  always_ff @(posedge clockIn or posedge reset) begin
    if (reset) cfg.wr_err <= 1'b0;
    else       cfg.wr_err <= cfg.wr_en && !wr_ok;
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [DIV_W-1:0] act_div, act_hi, sh_div, sh_hi, cnt;
    logic [DIV_W-1:0] nxt_div, nxt_hi, cnt_inc;
    logic             hit, wrap, pend, co, tk;

    // nxt_* is the configuration in force if this edge is an apply point.
    // A same-cycle write beats an older shadow, so the last write wins.
    always_comb begin
      hit     = wr_ok && (ch_ext == 32'(c));
      nxt_div = act_div;
      nxt_hi  = act_hi;
      if (hit) begin
        nxt_div = cfg.wr_div;
        nxt_hi  = cfg.wr_high;
      end else if (pend) begin
        nxt_div = sh_div;
        nxt_hi  = sh_hi;
      end
      wrap    = (cnt == act_div - DIV_W'(1));
      cnt_inc = cnt + DIV_W'(1);
    end

    always_ff @(posedge clockIn or posedge reset) begin
      if (reset) begin
        act_div <= DEF_DIV;
        act_hi  <= DEF_HI;
        sh_div  <= DEF_DIV;
        sh_hi   <= DEF_HI;
        cnt     <= DEF_DIV - DIV_W'(1);
        pend    <= 1'b0;
        co      <= 1'b0;
        tk      <= 1'b0;
      end else begin
        if (hit) begin
          sh_div <= cfg.wr_div;
          sh_hi  <= cfg.wr_high;
        end
        if (!enable[c]) begin
          // Parked at the last count, so the first enabled edge wraps to 0.
          act_div <= nxt_div;
          act_hi  <= nxt_hi;
          cnt     <= nxt_div - DIV_W'(1);
          pend    <= 1'b0;
          co      <= 1'b0;
          tk      <= 1'b0;
        end else if (wrap) begin
          act_div <= nxt_div;
          act_hi  <= nxt_hi;
          cnt     <= '0;
          pend    <= 1'b0;
          co      <= (nxt_hi != '0);
          tk      <= 1'b1;
        end else begin
          cnt <= cnt_inc;
          co  <= (cnt_inc < act_hi);
          tk  <= 1'b0;
          if (hit) pend <= 1'b1;
        end
      end
    end

    assign pending[c]  = pend;
    assign tick[c]     = tk;
    assign clockOut[c] = co;
  end
endmodule
